tl_sensor_cond: RTL and testbench
=================================

// Module: tl_sensor_cond
// PURPOSE
//   Upstream stage of tl_cntr. Conditions the raw vehicle-detector loops of street A and street B
//   and keeps a per-street count of queued cars.
//   Drives Ta/Tb (traffic present) into tl_cntr and reads back La/Lb to retire cars that pass on green.
//   Light code: 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 is treated as red.
// PARAMETERS
//   DEB_CYCLES   4   consecutive cycles a synchronized level must differ before debounced state flips (>=1)
//   PASS_CYCLES  3   green cycles needed to retire one queued car (>=1)
//   CNT_W        4   width of each queue counter; max count = 2**CNT_W-1
// PORTS
//   clk      in   1      system clock, rising edge
//   reset_n  in   1      asynchronous, active-low reset
//   raw_a    in   1      street A detector, asynchronous to clk, may bounce
//   raw_b    in   1      street B detector, asynchronous to clk, may bounce
//   La       in   2      current street A light from tl_cntr
//   Lb       in   2      current street B light from tl_cntr
//   Ta       out  1      street A traffic present = (cnt_a != 0)
//   Tb       out  1      street B traffic present = (cnt_b != 0)
//   cnt_a    out  CNT_W  street A queued-car count
//   cnt_b    out  CNT_W  street B queued-car count
//   ovf_a    out  1      sticky: street A arrival lost at saturation
//   ovf_b    out  1      sticky: street B arrival lost at saturation
// BEHAVIOUR
//   Reset (async assert): sync flops, debounced level, debounce counter, pass timer, cnt_*, ovf_* = 0.
//     Ta=Tb=0. Per-street debounce FSM goes to LOW.
//   Two identical, independent street channels. Ta/Tb are combinational from the cnt registers.
//   Sync: raw -> q1 -> q2, two flops.
//   Debounce FSM per street: LOW, RISE_CHK, HIGH, FALL_CHK.
//     LOW->RISE_CHK on q2=1. RISE_CHK->LOW if q2=0, debounce counter cleared.
//     RISE_CHK->HIGH when q2=1 on DEB_CYCLES consecutive edges. That edge is the arrival event.
//     HIGH->FALL_CHK on q2=0. FALL_CHK->HIGH if q2=1.
//     FALL_CHK->LOW after DEB_CYCLES consecutive q2=0 edges. No event on the fall.
//   Latency: raw sampled high at edge k and held -> cnt increments and Ta rises at edge k+DEB_CYCLES+1.
//   Pass timer per street:
//     Runs only while light==2'b00 and cnt!=0; otherwise held at 0.
//     When the timer reaches PASS_CYCLES-1 at an edge, that edge is a departure event and the timer
//       restarts from 0.
//     Yellow or red mid-count clears the timer; partial progress is discarded.
//   Counter update per edge:
//     arrival only -> +1, or hold at max and set ovf.
//     departure only -> -1.
//     both -> unchanged, no ovf.
//     neither -> hold.
//     Underflow cannot occur because departure requires cnt!=0.
//   ovf_* clears only on reset.
//   Reset mid-operation: partially debounced pulses and queued cars are discarded.
//     raw held high through reset release counts as one new arrival after full sync+debounce latency.
//   Bounce shorter than DEB_CYCLES cycles produces no event. One clean pulse produces exactly one arrival.
// CONFIGURATION
//   TL_SENSOR_DEBOUNCE_EN
//     defined: debounce FSM as above.
//     undefined: FSM and debounce counters removed; arrival = rising edge of q2 (q2 & ~q2_d).
//       Cnt/Ta update at edge k+2 after raw sampled high at edge k. Every glitch that survives sync counts.
//   Pass timer, saturation and ovf are identical in both builds.
// TESTING  (defaults, DEBOUNCE_EN defined, T=10)
//   1 Reset: reset_n=0 at t=1 with raw_a=raw_b=1 -> Ta=Tb=0, cnt_*=0, ovf_*=0 immediately (async).
//   2 Arrival: La=2'b10, raw_a 0->1 held 8 cycles -> cnt_a=1 and Ta=1 exactly 5 edges after first
//     high sample; cnt_b=0, Tb=0.
//   3 Bounce: raw_b toggled 1,0,1,0 on successive cycles, then 1 held -> exactly one arrival, cnt_b=1.
//     A 3-cycle pulse alone -> cnt_b stays 0.
//   4 Departure: cnt_a=2, La=2'b00 -> cnt_a=1 after 3 edges, 0 after 6 edges, Ta=0.
//     La set to 2'b01 after 2 green edges -> cnt_a unchanged, timer cleared.
//   5 Simultaneous: cnt_a=1, La=00, arrival coincides with departure edge -> cnt_a stays 1, Ta stays 1.
//   6 Saturation: 16 clean pulses on raw_b with Lb=2'b10 -> cnt_b=15, ovf_b=1.
//     Then Lb=00 drains cnt_b to 0 in 45 edges; ovf_b remains 1 until reset.

Source files
------------

// File: rtl/tl_sensor_cond.sv
// -----------------------------------------------------------------------------
// tl_sensor_cond
//   Conditions the raw vehicle-detector loops of street A and street B and
//   keeps a per-street count of queued cars. Ta/Tb tell the downstream light
//   controller that traffic is waiting. La/Lb are read back so that cars can be
//   retired while their street shows green.
//
//   Light code: 2'b00 green, 2'b01 yellow, 2'b10 red, 2'b11 treated as red.
//
// Build option
//   TL_SENSOR_DEBOUNCE_EN
//     defined   : each street uses a debounce FSM and counts one arrival per
//                 stable low->high transition.
//     undefined : no debounce. An arrival is the rising edge of the
//                 synchronized detector level.
//   The pass timer, saturation and overflow flags are the same in both builds.
//
// Parameters
//   DEB_CYCLES   consecutive cycles a level must differ before the debounced
//                state flips (>= 1)
//   PASS_CYCLES  green cycles needed to retire one queued car (>= 1)
//   CNT_W        width of each queue counter
//
// Ports
//   clk      in   1      system clock, rising edge
//   reset_n  in   1      asynchronous, active-low reset
//   raw_a    in   1      street A detector, asynchronous, may bounce
//   raw_b    in   1      street B detector, asynchronous, may bounce
//   La       in   2      street A light
//   Lb       in   2      street B light
//   Ta       out  1      street A traffic present (cnt_a != 0)
//   Tb       out  1      street B traffic present (cnt_b != 0)
//   cnt_a    out  CNT_W  street A queued-car count
//   cnt_b    out  CNT_W  street B queued-car count
//   ovf_a    out  1      sticky: street A arrival lost at saturation
//   ovf_b    out  1      sticky: street B arrival lost at saturation
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// tl_sensor_chan
//   One street: two-flop synchronizer, arrival detection, pass timer and the
//   saturating queue counter.
//
//   Ports
//     clk, reset_n  clock and asynchronous active-low reset
//     raw           detector input, asynchronous
//     light         this street's light code
//     cnt           queued-car count
//     ovf           sticky saturation flag
//
//   Debounce FSM (only with TL_SENSOR_DEBOUNCE_EN)
//     state      | meaning
//     -----------+--------------------------------------------------------
//     S_LOW      | debounced level is 0, waiting for the input to go high
//     S_RISE_CHK | input high, counting towards DEB_CYCLES high samples
//     S_HIGH     | debounced level is 1 (arrival already counted)
//     S_FALL_CHK | input low, counting towards DEB_CYCLES low samples
// -----------------------------------------------------------------------------
module tl_sensor_chan #(
`ifdef TL_SENSOR_DEBOUNCE_EN
  parameter int DEB_CYCLES  = 4,
`endif
  parameter int PASS_CYCLES = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw,
  input  logic [1:0]       light,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam int PT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam logic [PT_W-1:0] PASS_LAST = PT_W'(PASS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  logic arrival;

`ifdef TL_SENSOR_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debounce FSM
  //   The transition out of S_LOW (or S_HIGH) already counts as the first of
  //   the DEB_CYCLES samples, so the down-counter is loaded with DEB_CYCLES-2
  //   and the terminal count (0) marks the last required sample.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } deb_state_e;

  localparam int DC_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES - 1) : 1;
  localparam logic [DC_W-1:0] DEB_LOAD = DC_W'((DEB_CYCLES > 1) ? DEB_CYCLES - 2 : 0);
  localparam bit DEB_ONE = (DEB_CYCLES == 1);

  deb_state_e      state_q, state_d;
  logic [DC_W-1:0] deb_cnt_q, deb_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_LOW;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          if (DEB_ONE) begin
            state_d = S_HIGH;
          end else begin
            state_d   = S_RISE_CHK;
            deb_cnt_d = DEB_LOAD;
          end
        end
      end
      S_RISE_CHK: begin
        if (!sync2_q) begin
          state_d   = S_LOW;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == '0) begin
          state_d = S_HIGH;
        end else begin
          deb_cnt_d = deb_cnt_q - DC_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync2_q) begin
          if (DEB_ONE) begin
            state_d = S_LOW;
          end else begin
            state_d   = S_FALL_CHK;
            deb_cnt_d = DEB_LOAD;
          end
        end
      end
      S_FALL_CHK: begin
        if (sync2_q) begin
          state_d   = S_HIGH;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == '0) begin
          state_d = S_LOW;
        end else begin
          deb_cnt_d = deb_cnt_q - DC_W'(1);
        end
      end
      default: begin
        state_d   = S_LOW;
        deb_cnt_d = '0;
      end
    endcase
  end

  // The edge that moves the FSM into S_HIGH is the arrival event.
  always_comb begin
    arrival = 1'b0;
    case (state_q)
      S_LOW:      arrival = DEB_ONE && sync2_q;
      S_RISE_CHK: arrival = sync2_q && (deb_cnt_q == '0);
      default:    arrival = 1'b0;
    endcase
  end
`else
  // ---------------------------------------------------------------------------
  // No debounce: every rising edge of the synchronized level is an arrival.
  // ---------------------------------------------------------------------------
  logic sync2_dly_q, sync2_dly_d;

  always_comb begin
    sync2_dly_d = sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync2_dly_q <= 1'b0;
    end else begin
      sync2_dly_q <= sync2_dly_d;
    end
  end

  always_comb begin
    arrival = sync2_q & ~sync2_dly_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Pass timer and queue counter
  //   The timer only advances while the light is green and a car is queued;
  //   any other light discards partial progress. A departure therefore always
  //   has cnt != 0, so the decrement cannot underflow.
  // ---------------------------------------------------------------------------
  logic [PT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             running;
  logic             departure;

  always_comb begin
    running   = (light == 2'b00) && (cnt_q != '0);
    departure = running && (timer_q == PASS_LAST);
    timer_d   = (running && !departure) ? timer_q + PT_W'(1) : '0;

    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case ({arrival, departure})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// -----------------------------------------------------------------------------
// Top level: two identical, independent street channels.
// -----------------------------------------------------------------------------
module tl_sensor_cond #(
  parameter int DEB_CYCLES  = 4,
  parameter int PASS_CYCLES = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             ovf_a,
  output logic             ovf_b
);

  if (DEB_CYCLES < 1 || PASS_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("tl_sensor_cond: DEB_CYCLES, PASS_CYCLES and CNT_W must all be >= 1");
  end

  tl_sensor_chan #(
`ifdef TL_SENSOR_DEBOUNCE_EN
    .DEB_CYCLES  (DEB_CYCLES),
`endif
    .PASS_CYCLES (PASS_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_a),
    .light   (La),
    .cnt     (cnt_a),
    .ovf     (ovf_a)
  );

  tl_sensor_chan #(
`ifdef TL_SENSOR_DEBOUNCE_EN
    .DEB_CYCLES  (DEB_CYCLES),
`endif
    .PASS_CYCLES (PASS_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_b),
    .light   (Lb),
    .cnt     (cnt_b),
    .ovf     (ovf_b)
  );

  assign Ta = (cnt_a != '0);
  assign Tb = (cnt_b != '0);

endmodule

// File: tb/tb_tl_sensor_cond.sv
module tb_tl_sensor_cond;

  localparam int DEB   = 4;
  localparam int PASS  = 3;
  localparam int W     = 4;
`ifdef TL_SENSOR_DEBOUNCE_EN
  localparam bit DEB_BUILD = 1'b1;
`else
  localparam bit DEB_BUILD = 1'b0;
`endif
  // edges from the first high sample to the count update
  localparam int LAT = DEB_BUILD ? DEB + 1 : 2;

  logic         clk;
  logic         reset_n;
  logic         raw_a, raw_b;
  logic [1:0]   La, Lb;
  logic         Ta, Tb;
  logic [W-1:0] cnt_a, cnt_b;
  logic         ovf_a, ovf_b;

  int n_checks;
  int n_err;

  tl_sensor_cond #(
    .DEB_CYCLES  (DEB),
    .PASS_CYCLES (PASS),
    .CNT_W       (W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .La      (La),
    .Lb      (Lb),
    .Ta      (Ta),
    .Tb      (Tb),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .ovf_a   (ovf_a),
    .ovf_b   (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pat_a;   // raw_a per cycle, bit 0 first
    logic [15:0] pat_b;
    int          da_deb;  // expected arrivals, debounce build
    int          db_deb;
    int          da_nd;   // expected arrivals, no-debounce build
    int          db_nd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one clean 8-cycle pulse, then enough idle time for the fall to settle
  task automatic pulse(input bit street_b);
    if (street_b) raw_b = 1'b1; else raw_a = 1'b1;
    repeat (8) tick();
    raw_a = 1'b0;
    raw_b = 1'b0;
    repeat (14) tick();
  endtask

  initial begin
    int exp_a, exp_b;
    n_checks = 0;
    n_err    = 0;

    vecs[0] = '{"clean8_a",      16'h00FF, 16'h0000, 1, 0, 1, 0};
    vecs[1] = '{"bounce_b",      16'h0000, 16'h03F5, 0, 1, 0, 3};
    vecs[2] = '{"short3_b",      16'h0000, 16'h0007, 0, 0, 0, 1};
    vecs[3] = '{"exact4_ab",     16'h000F, 16'h000F, 1, 1, 1, 1};
    vecs[4] = '{"glitch_a_gap_b",16'h0005, 16'h01EF, 0, 1, 2, 2};
    vecs[5] = '{"gap_a_spike_b", 16'h01EF, 16'h0001, 1, 0, 2, 1};

    // ---- async reset with detectors high ----
    reset_n = 1'b1;
    raw_a   = 1'b1;
    raw_b   = 1'b1;
    La      = 2'b10;
    Lb      = 2'b10;
    #1 reset_n = 1'b0;
    #1;
    chk("rst cnt_a", cnt_a, 0);
    chk("rst cnt_b", cnt_b, 0);
    chk("rst Ta", Ta, 0);
    chk("rst Tb", Tb, 0);
    chk("rst ovf_a", ovf_a, 0);
    chk("rst ovf_b", ovf_b, 0);

    // ---- raw held through release: one arrival after full latency ----
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (LAT) tick();
    chk("lat early cnt_a", cnt_a, 0);
    chk("lat early Ta", Ta, 0);
    tick();
    chk("lat cnt_a", cnt_a, 1);
    chk("lat Ta", Ta, 1);
    chk("lat cnt_b", cnt_b, 1);
    chk("lat Tb", Tb, 1);
    raw_a = 1'b0;
    raw_b = 1'b0;
    repeat (14) tick();
    chk("fall no event cnt_a", cnt_a, 1);

    // ---- table of detector patterns, lights red ----
    exp_a = 1;
    exp_b = 1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin
        raw_a = vecs[v].pat_a[i];
        raw_b = vecs[v].pat_b[i];
        tick();
      end
      exp_a += DEB_BUILD ? vecs[v].da_deb : vecs[v].da_nd;
      exp_b += DEB_BUILD ? vecs[v].db_deb : vecs[v].db_nd;
      chk($sformatf("%s cnt_a", vecs[v].name), cnt_a, exp_a);
      chk($sformatf("%s cnt_b", vecs[v].name), cnt_b, exp_b);
      chk($sformatf("%s Ta", vecs[v].name), Ta, 1);
      chk($sformatf("%s ovf_b", vecs[v].name), ovf_b, 0);
    end

    // ---- reset mid-operation discards queued cars ----
    tick();
    #3 reset_n = 1'b0;
    #1;
    chk("midrst cnt_a", cnt_a, 0);
    chk("midrst cnt_b", cnt_b, 0);
    chk("midrst Tb", Tb, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // ---- departure: two cars drain in 3-edge steps ----
    pulse(1'b0);
    pulse(1'b0);
    chk("dep pre cnt_a", cnt_a, 2);
    La = 2'b00;
    repeat (2) tick();
    chk("dep 2 edges cnt_a", cnt_a, 2);
    tick();
    chk("dep 3 edges cnt_a", cnt_a, 1);
    repeat (3) tick();
    chk("dep 6 edges cnt_a", cnt_a, 0);
    chk("dep 6 edges Ta", Ta, 0);
    repeat (2) tick();
    chk("dep idle green cnt_a", cnt_a, 0);
    La = 2'b10;

    // ---- yellow mid-count clears the timer ----
    pulse(1'b0);
    pulse(1'b0);
    La = 2'b00;
    repeat (2) tick();
    La = 2'b01;
    tick();
    chk("yel cnt_a", cnt_a, 2);
    La = 2'b00;
    repeat (2) tick();
    chk("yel restart 2 cnt_a", cnt_a, 2);
    tick();
    chk("yel restart 3 cnt_a", cnt_a, 1);
    La = 2'b10;

    // ---- arrival on the same edge as a departure ----
    raw_a = 1'b1;
    repeat (LAT - 2) tick();
    La = 2'b00;
    repeat (2) tick();
    chk("simul pre cnt_a", cnt_a, 1);
    tick();
    chk("simul cnt_a", cnt_a, 1);
    chk("simul Ta", Ta, 1);
    chk("simul ovf_a", ovf_a, 0);
    La = 2'b10;
    raw_a = 1'b0;
    repeat (14) tick();
    chk("simul settle cnt_a", cnt_a, 1);

    // ---- saturation on street B ----
    tick();
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    for (int p = 0; p < 15; p++) pulse(1'b1);
    chk("sat 15 cnt_b", cnt_b, 15);
    chk("sat 15 ovf_b", ovf_b, 0);
    pulse(1'b1);
    chk("sat 16 cnt_b", cnt_b, 15);
    chk("sat 16 ovf_b", ovf_b, 1);
    chk("sat 16 Tb", Tb, 1);
    chk("sat ovf_a", ovf_a, 0);
    Lb = 2'b00;
    repeat (44) tick();
    chk("drain 44 cnt_b", cnt_b, 1);
    tick();
    chk("drain 45 cnt_b", cnt_b, 0);
    chk("drain Tb", Tb, 0);
    chk("drain ovf_b sticky", ovf_b, 1);
    repeat (5) tick();
    chk("idle ovf_b sticky", ovf_b, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("final rst ovf_b", ovf_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
